// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  // ID-stage redirect select encodings
  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  // Word presented to IF/ID when no real instruction is available
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } fetch_state_e;

  // Force a byte address onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Request/ready handshake between the fetch stage and instruction memory.
interface if_fetch_stage_if;

  logic                               imem_req;
  logic [if_fetch_stage_pkg::XLEN-1:0] imem_addr;
  logic [if_fetch_stage_pkg::XLEN-1:0] imem_rdata;
  logic                               imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/if_npc_mux.sv
// Next-PC select: a pending redirect overrides the live ID-stage select.
module if_npc_mux
  import if_fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] ra,
  input  logic [XLEN-1:0] jpc,
  input  logic            pend,
  input  logic [XLEN-1:0] pend_tgt,
  output logic [XLEN-1:0] sel_tgt,
  output logic [XLEN-1:0] npc
);

  // Live redirect target, word aligned; pc+4 wraps modulo 2^32
  always_comb begin
    sel_tgt = pc + XLEN'(4);
    unique case (pcsource)
      PCS_SEQ: sel_tgt = pc + XLEN'(4);
      PCS_BR:  sel_tgt = word_align(bpc);
      PCS_JR:  sel_tgt = word_align(ra);
      PCS_J:   sel_tgt = word_align(jpc);
      default: sel_tgt = pc + XLEN'(4);
    endcase
  end

  assign npc = pend ? pend_tgt : sel_tgt;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready, and presents
// one instruction (or a bubble) per cycle to IF/ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_fetch_stage_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   wpcir,
  input  logic [1:0]             pcsource,
  input  logic [XLEN-1:0]        bpc,
  input  logic [XLEN-1:0]        ra,
  input  logic [XLEN-1:0]        jpc,
  if_fetch_stage_if.master       imem,
  output logic [XLEN-1:0]        if_pc4,
  output logic [XLEN-1:0]        if_inst,
  output logic                   if_valid
);

  localparam logic [XLEN-1:0] PC_INIT = RESET_PC & ~XLEN'(3);

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst_buf;
  logic            pend;
  logic [XLEN-1:0] pend_tgt;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] sel_tgt;

  logic            pc_we;
  logic            buf_we;
  logic            deliver;
  logic            fetch_hit;
  logic            capture;

  if_npc_mux u_npc_mux (
    .pc       (pc),
    .pcsource (pcsource),
    .bpc      (bpc),
    .ra       (ra),
    .jpc      (jpc),
    .pend     (pend),
    .pend_tgt (pend_tgt),
    .sel_tgt  (sel_tgt),
    .npc      (npc)
  );

  // State register; reset drops the request immediately
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and datapath enables; a stall never abandons an outstanding fetch
  always_comb begin
    state_d   = state;
    pc_we     = 1'b0;
    buf_we    = 1'b0;
    deliver   = 1'b0;
    fetch_hit = 1'b0;
    unique case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
          fetch_hit = 1'b1;
          deliver   = 1'b1;
          if (wpcir) begin
            pc_we = 1'b1;
          end else begin
            buf_we  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        deliver = 1'b1;
        if (wpcir) begin
          pc_we   = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Redirect seen while nothing is delivered must wait for the in-flight slot
  assign capture = wpcir && (pcsource != PCS_SEQ) && !deliver;

  // PC register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)      pc <= PC_INIT;
    else if (pc_we) pc <= npc;
  end

  // Holding buffer for the word fetched during a stall
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)       inst_buf <= NOP_INST;
    else if (buf_we) inst_buf <= imem.imem_rdata;
  end

  // Pending redirect, consumed by the next PC advance
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pend     <= 1'b0;
      pend_tgt <= PC_INIT;
    end else if (pc_we) begin
      pend     <= 1'b0;
    end else if (capture) begin
      pend     <= 1'b1;
      pend_tgt <= sel_tgt;
    end
  end

  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign if_pc4         = pc + XLEN'(4);
  assign if_valid       = deliver;

  // Presented word: memory data on a hit, buffer while holding, else bubble
  always_comb begin
    if_inst = NOP_INST;
    if (fetch_hit)           if_inst = imem.imem_rdata;
    else if (state == HOLD)  if_inst = inst_buf;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the PC, drives a req/ready handshake to instruction memory, and selects the next PC from the ID-stage redirect (branch, jr, j) with one delay slot. It presents if_pc4/if_inst/if_valid to IF/ID, inserts NOP bubbles while memory is busy, and holds the fetched instruction while the hazard unit stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word presented when no valid instruction is available

Ports:
clk  in  1  pipeline clock, all state on posedge
clrn  in  1  asynchronous active-low reset
wpcir  in  1  hazard-unit PC write enable: 1 = advance, 0 = stall
pcsource  in  2  ID redirect select: 00 pc+4, 01 bpc, 10 ra (jr), 11 jpc
bpc  in  32  branch target from ID
ra  in  32  register target (jr) from ID
jpc  in  32  jump target from ID
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address, word aligned
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  memory completes the request this cycle
if_pc4  out  32  PC+4 of the presented instruction, to IF/ID
if_inst  out  32  presented instruction, to IF/ID
if_valid  out  1  1 = if_inst is a real instruction, 0 = bubble

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (clrn).
- Reset values: pc=RESET_PC; state=IDLE; imem_req=0; pend=0; buf=NOP_INST; if_valid=0; if_inst=NOP_INST; if_pc4=RESET_PC+4.
- PC handling: pc[1:0] is always 00 and target bits [1:0] are ignored. imem_addr=pc. if_pc4=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- States:
  - IDLE: one cycle after reset release, then go to FETCH.
  - FETCH: imem_req=1.
  - HOLD: imem_req=0, buf is presented.
- Delivery: deliver = (FETCH & imem_ready) | HOLD.
  - FETCH & imem_ready: if_inst=imem_rdata (combinational, same cycle), if_valid=1.
  - HOLD: if_inst=buf, if_valid=1.
  - Otherwise: if_inst=NOP_INST, if_valid=0.
- Next PC: npc = pend ? pend_tgt : mux(pcsource; pc+4, bpc, ra, jpc).
- FETCH & imem_ready & wpcir: pc<=npc, pend<=0, stay in FETCH. Back-to-back fetches give 1 instruction/cycle with zero-wait memory.
- FETCH & imem_ready & !wpcir: buf<=imem_rdata, go to HOLD, pc unchanged.
- FETCH & !imem_ready: stay. imem_req and imem_addr stay stable until ready, regardless of wpcir. An outstanding request is never abandoned.
- HOLD & wpcir: pc<=npc, pend<=0, go to FETCH. HOLD & !wpcir: stay.
- Redirect capture: pcsource is honoured only when wpcir=1. If wpcir=1, pcsource!=00 and !deliver, then pend<=1 and pend_tgt<=selected target. This covers a branch leaving ID while the delay slot is still being fetched. If pend is already set, a new capture overwrites it; this is legal only if pcsource=00, which the hazard unit guarantees.
- Delay slot: the instruction delivered with or after the redirect is always the sequential one. The redirect applies to the fetch that follows it.
- Reset mid-transaction: immediately drop imem_req, return to the reset values, and ignore any late imem_ready. The memory must tolerate a dropped request.

Decomposition:
- Shared package/header holds:
  - pcsource encodings (PCS_SEQ=2'b00, PCS_BR=2'b01, PCS_JR=2'b10, PCS_J=2'b11)
  - state encodings (IDLE, FETCH, HOLD)
  - NOP_INST
- One sub-module: if_npc_mux, a combinational 4:1 next-PC select that includes the pend override.
- Everything else (FSM, pc, buf, pend registers) stays in if_fetch_stage.

Test Plan:
- Reset then zero-wait memory (ready tied 1, rdata=addr^32'hA5A5_0000), wpcir=1: addresses go 0,4,8,C. if_valid=0 in the IDLE cycle, then 1 every cycle. if_pc4 is 4,8,C,10.
- Memory with 2 wait states at pc=8: if_valid=0 for 2 cycles with if_inst=NOP and imem_addr held at 8. Delivered on the 3rd cycle, then the pc=C request follows.
- wpcir=0 for 3 cycles while ready=1 at pc=10: state HOLD, imem_req=0, if_inst stays the word fetched at 10. On wpcir=1 the next request is at 14.
- Branch: pcsource=01, bpc=32'h100 while delay slot pc=14 is delivered: delivered 14, then fetched 100, with if_pc4=104.
- Redirect during memory wait: pcsource=11, jpc=32'h200 in a cycle with ready=0 (pend set), pcsource=00 afterwards: the pending fetch completes at its address, then the next fetch is 200.
- clrn pulsed low while FETCH is waiting on ready: imem_req=0 asynchronously, pc=RESET_PC. After release, IDLE for one cycle, then a fetch at 0.
